wb_stage: RTL and testbench

Write-back stage of the NPC five-stage pipeline, directly downstream of the memory stage. It accepts one retiring instruction per valid/ready handshake and commits it one cycle later. It owns the 32×32 general register file, the machine CSRs and the retire counter. It detects `ebreak` and freezes the pipeline into a halt state for the simulation harness.

---
 rtl/wb_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : write-back stage of the NPC five-stage pipeline.
//
// Accepts one retiring instruction per valid/ready handshake. The instruction
// commits in the cycle after capture. This stage owns the 32x32 GPR file, the
// machine CSRs (mstatus, mtvec, mepc, mcause) and the minstret retire counter.
// When an ebreak retires, the stage freezes into HALT and reports x10 as the
// halt code. Only reset leaves HALT.
//
// Optional feature macro: WB_MINSTRET_EN
//   defined   : 64-bit minstret present, readable at 0xB02 / 0xB82
//   undefined : counter removed, both addresses read 0
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   pc, inst                incoming instruction PC and word
//   R_wen, rd               GPR write request and destination
//   mem_ren, MEM_Rdata      load-data select and load data
//   Ex_result               ALU / link result
//   csr_wen, csrs           one-hot CSR write enable and write data
//   jump_flag               redirect marker, passed to the trace
//   valid_last, ready_last  upstream handshake
//   rs1_addr/rs2_addr       decode GPR read ports (rs1_data/rs2_data, bypassed)
//   csr_raddr, csr_rdata    decode CSR read port (bypassed)
//   commit_*                per-retirement trace outputs
//   halt, halt_code         ebreak halt indication and x10 at that point
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        R_wen,
  input  logic [4:0]  rd,
  input  logic        mem_ren,
  input  logic [31:0] MEM_Rdata,
  input  logic [31:0] Ex_result,
  input  logic [3:0]  csr_wen,
  input  logic [31:0] csrs,
  input  logic        jump_flag,
  input  logic        valid_last,
  output logic        ready_last,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        commit_jump,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam logic [31:0] EBREAK       = 32'h0010_0073;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q;
  logic [31:0] halt_code_q;

  // Captured instruction (one-entry stage register)
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        rwen_q;
  logic [4:0]  rd_q;
  logic        memren_q;
  logic [31:0] memrdata_q;
  logic [31:0] exres_q;
  logic [3:0]  csrwen_q;
  logic [31:0] csrs_q;
  logic        jump_q;

  // Architectural state
  logic [31:0] gpr_q [32];
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
`ifdef WB_MINSTRET_EN
  logic [63:0] minstret_q;
`endif

  logic        commit;
  logic        is_ebreak;
  logic        capture;
  logic        gpr_we;
  logic [31:0] gpr_wdata;
  logic [3:0]  csr_we;

  // Commit only in RUN; after the ebreak commit valid_q never re-arms anyway,
  // the state term simply makes the freeze explicit.
  assign commit    = valid_q && (state_q == S_RUN);
  assign is_ebreak = commit && (inst_q == EBREAK);

  // A capture in the ebreak commit cycle is dropped: state_d already says HALT.
  assign capture   = valid_last && ready_q && (state_d == S_RUN);

  assign gpr_we    = commit && rwen_q && (rd_q != 5'd0);
  assign gpr_wdata = memren_q ? memrdata_q : exres_q;
  assign csr_we    = commit ? csrwen_q : 4'b0000;

  // ---------------------------------------------------------------------------
  // FSM: RUN until an ebreak retires, then HALT until reset
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (is_ebreak) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      ready_q     <= 1'b1;
      halt_code_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_RUN);
      // ebreak writes no GPR, so storage already holds the final x10
      if (is_ebreak) halt_code_q <= gpr_q[10];
    end
  end

  assign ready_last = ready_q;
  assign halt       = (state_q == S_HALT);
  assign halt_code  = halt_code_q;

  // ---------------------------------------------------------------------------
  // Capture stage: register the handshaked instruction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      rwen_q     <= 1'b0;
      rd_q       <= '0;
      memren_q   <= 1'b0;
      memrdata_q <= '0;
      exres_q    <= '0;
      csrwen_q   <= '0;
      csrs_q     <= '0;
      jump_q     <= 1'b0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        pc_q       <= pc;
        inst_q     <= inst;
        rwen_q     <= R_wen;
        rd_q       <= rd;
        memren_q   <= mem_ren;
        memrdata_q <= MEM_Rdata;
        exres_q    <= Ex_result;
        csrwen_q   <= csr_wen;
        csrs_q     <= csrs;
        jump_q     <= jump_flag;
      end
    end
  end

  assign commit_valid = valid_q;
  assign commit_pc    = pc_q;
  assign commit_inst  = inst_q;
  assign commit_jump  = jump_q;

  // ---------------------------------------------------------------------------
  // Commit stage: GPR, CSR and retire-counter updates
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (gpr_we) begin
      gpr_q[rd_q] <= gpr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q <= RESET_MSTATUS;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      if (csr_we[0]) mstatus_q <= csrs_q;
      if (csr_we[1]) mtvec_q   <= csrs_q;
      if (csr_we[2]) mepc_q    <= csrs_q;
      if (csr_we[3]) mcause_q  <= csrs_q;
    end
  end

`ifdef WB_MINSTRET_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      minstret_q <= '0;
    end else if (commit) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read ports with same-cycle bypass of the committing write
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_data = gpr_q[rs1_addr];
    if (gpr_we && (rs1_addr == rd_q)) rs1_data = gpr_wdata;
    if (rs1_addr == 5'd0)             rs1_data = '0;
  end

  always_comb begin
    rs2_data = gpr_q[rs2_addr];
    if (gpr_we && (rs2_addr == rd_q)) rs2_data = gpr_wdata;
    if (rs2_addr == 5'd0)             rs2_data = '0;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:  csr_rdata = csr_we[0] ? csrs_q : mstatus_q;
      CSR_MTVEC:    csr_rdata = csr_we[1] ? csrs_q : mtvec_q;
      CSR_MEPC:     csr_rdata = csr_we[2] ? csrs_q : mepc_q;
      CSR_MCAUSE:   csr_rdata = csr_we[3] ? csrs_q : mcause_q;
`ifdef WB_MINSTRET_EN
      CSR_MINSTRET: csr_rdata = minstret_q[31:0];
      CSR_MINSTRH:  csr_rdata = minstret_q[63:32];
`else
      CSR_MINSTRET: csr_rdata = '0;
      CSR_MINSTRH:  csr_rdata = '0;
`endif
      default:      csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        R_wen;
  logic [4:0]  rd;
  logic        mem_ren;
  logic [31:0] MEM_Rdata;
  logic [31:0] Ex_result;
  logic [3:0]  csr_wen;
  logic [31:0] csrs;
  logic        jump_flag;
  logic        valid_last;
  logic        ready_last;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_jump;
  logic        halt;
  logic [31:0] halt_code;

  wb_stage #(.RESET_MSTATUS(32'h0000_1800)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd),
    .mem_ren(mem_ren), .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result),
    .csr_wen(csr_wen), .csrs(csrs), .jump_flag(jump_flag),
    .valid_last(valid_last), .ready_last(ready_last),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_jump(commit_jump), .halt(halt), .halt_code(halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every commit pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    if (rst_n && commit_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", {32'd0, commit_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_pc",   {32'd0, commit_pc},   {32'd0, e.pc});
        chk("commit_inst", {32'd0, commit_inst}, {32'd0, e.inst});
        chk("commit_jump", {63'd0, commit_jump}, {63'd0, e.jump});
      end
    end
  end

  // Called at a negedge; drives one beat and returns at the next negedge
  // (the commit cycle of this beat), with valid_last dropped.
  task automatic send(input logic [31:0] a_pc, input logic [31:0] a_inst,
                      input logic a_rwen, input logic [4:0] a_rd,
                      input logic a_memren, input logic [31:0] a_mrd,
                      input logic [31:0] a_ex, input logic [3:0] a_cwen,
                      input logic [31:0] a_csrs, input logic a_jump,
                      input bit expect_commit);
    exp_t e;
    pc = a_pc; inst = a_inst; R_wen = a_rwen; rd = a_rd; mem_ren = a_memren;
    MEM_Rdata = a_mrd; Ex_result = a_ex; csr_wen = a_cwen; csrs = a_csrs;
    jump_flag = a_jump; valid_last = 1'b1;
    if (expect_commit) begin
      e.pc = a_pc; e.inst = a_inst; e.jump = a_jump;
      exp_q.push_back(e);
    end
    @(negedge clk);
    valid_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; inst = '0; R_wen = 1'b0; rd = '0; mem_ren = 1'b0;
    MEM_Rdata = '0; Ex_result = '0; csr_wen = '0; csrs = '0; jump_flag = 1'b0;
    valid_last = 1'b0; rs1_addr = '0; rs2_addr = '0; csr_raddr = 12'h300;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready",   {63'd0, ready_last},   64'd1);
    chk("rst_halt",    {63'd0, halt},         64'd0);
    chk("rst_hcode",   {32'd0, halt_code},    64'd0);
    chk("rst_cvalid",  {63'd0, commit_valid}, 64'd0);
    chk("rst_cpc",     {32'd0, commit_pc},    64'd0);
    chk("rst_mstatus", {32'd0, csr_rdata},    64'h1800);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write with bypass, then from storage
    send(32'h100, NOP, 1'b1, 5'd5, 1'b0, 32'h0, 32'h1234, 4'b0, 32'h0, 1'b1, 1'b1);
    rs1_addr = 5'd5; #1;
    chk("x5_bypass", {32'd0, rs1_data}, 64'h1234);
    @(negedge clk);
    rs2_addr = 5'd5; #1;
    chk("x5_rs1_store", {32'd0, rs1_data}, 64'h1234);
    chk("x5_rs2_store", {32'd0, rs2_data}, 64'h1234);

    // x0 stays zero; load data selected over Ex_result
    @(negedge clk);
    send(32'h104, NOP, 1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'b0, 32'h0, 1'b0, 1'b1);
    rs1_addr = 5'd0; #1;
    chk("x0_bypass", {32'd0, rs1_data}, 64'd0);
    @(negedge clk);
    chk("x0_store", {32'd0, rs1_data}, 64'd0);
    send(32'h108, NOP, 1'b1, 5'd3, 1'b1, 32'h80, 32'h1, 4'b0, 32'h0, 1'b0, 1'b1);
    rs2_addr = 5'd3; #1;
    chk("x3_bypass", {32'd0, rs2_data}, 64'h80);
    @(negedge clk);
    chk("x3_store", {32'd0, rs2_data}, 64'h80);

    // CSR write to mtvec and mepc
    send(32'h10C, NOP, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'b0110, 32'h8000_0100, 1'b0, 1'b1);
    csr_raddr = 12'h305; #1;
    chk("mtvec_bypass", {32'd0, csr_rdata}, 64'h8000_0100);
    @(negedge clk);
    csr_raddr = 12'h305; #1; chk("mtvec",   {32'd0, csr_rdata}, 64'h8000_0100);
    csr_raddr = 12'h341; #1; chk("mepc",    {32'd0, csr_rdata}, 64'h8000_0100);
    csr_raddr = 12'h300; #1; chk("mstatus", {32'd0, csr_rdata}, 64'h1800);
    csr_raddr = 12'h342; #1; chk("mcause",  {32'd0, csr_rdata}, 64'h0);
    csr_raddr = 12'h123; #1; chk("csr_unmapped", {32'd0, csr_rdata}, 64'h0);
    @(negedge clk);

    // Retire count: fresh reset, 10 back-to-back beats
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(32'h200 + 32'(i * 4), NOP, 1'b1, 5'd10, 1'b0, 32'h0, 32'(i), 4'b0, 32'h0,
           i[0], 1'b1);
      #1;
      chk("b2b_cvalid", {63'd0, commit_valid}, 64'd1);
    end
    @(negedge clk);
    chk("b2b_idle", {63'd0, commit_valid}, 64'd0);
    csr_raddr = 12'hB02; #1;
`ifdef WB_MINSTRET_EN
    chk("minstret_lo", {32'd0, csr_rdata}, 64'd10);
`else
    chk("minstret_lo", {32'd0, csr_rdata}, 64'd0);
`endif
    csr_raddr = 12'hB82; #1;
    chk("minstret_hi", {32'd0, csr_rdata}, 64'd0);
    rs1_addr = 5'd10; #1;
    chk("x10_last", {32'd0, rs1_data}, 64'd9);
    @(negedge clk);

    // Halt: x10 = 7, ebreak, then a beat in the ebreak commit cycle is dropped
    send(32'h300, NOP, 1'b1, 5'd10, 1'b0, 32'h0, 32'd7, 4'b0, 32'h0, 1'b0, 1'b1);
    send(32'h304, EBREAK, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b1);
    send(32'h308, NOP, 1'b1, 5'd10, 1'b0, 32'h0, 32'hDEAD, 4'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("halt",        {63'd0, halt},       64'd1);
    chk("halt_code",   {32'd0, halt_code},  64'd7);
    chk("halt_ready",  {63'd0, ready_last}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      send(32'h400 + 32'(i * 4), NOP, 1'b1, 5'd10, 1'b0, 32'h0, 32'hBEEF, 4'b0001,
           32'h5, 1'b0, 1'b0);
      #1;
      chk("halt_no_commit", {63'd0, commit_valid}, 64'd0);
    end
    rs1_addr = 5'd10; csr_raddr = 12'h300; #1;
    chk("halt_x10_frozen", {32'd0, rs1_data}, 64'd7);
    chk("halt_csr_frozen", {32'd0, csr_rdata}, 64'h1800);
    chk("halt_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Reset out of HALT
    do_reset();
    rs1_addr = 5'd10; csr_raddr = 12'hB02; #1;
    chk("rst2_halt",     {63'd0, halt},       64'd0);
    chk("rst2_ready",    {63'd0, ready_last}, 64'd1);
    chk("rst2_x10",      {32'd0, rs1_data},   64'd0);
    chk("rst2_minstret", {32'd0, csr_rdata},  64'd0);
    chk("rst2_hcode",    {32'd0, halt_code},  64'd0);

    // Pipeline runs again after reset
    @(negedge clk);
    send(32'h500, NOP, 1'b1, 5'd1, 1'b0, 32'h0, 32'h55, 4'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rs1_addr = 5'd1; #1;
    chk("post_rst_x1", {32'd0, rs1_data}, 64'h55);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
